dds_cmd_arb: RTL
================

DDS_CMD_ARB -- requirements
Module: dds_cmd_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 4096, max cycles per wait state before watchdog abort (16-bit).
REQ-002 SHALL have parameter CMDW, default 37, DDS command word width.
REQ-003 wClk_i  in  1  sole clock; all logic on rising edge.
REQ-004 wResetN_i  in  1  reset, synchronous, active-low.
REQ-005 wSeqTrig_i / wSeqBrdIdx_i / wSeqCmd_i  in  1/4/CMDW  sequencer command strobe (1-cycle pulse), board index, command word.
REQ-006 wSeqRun_i  in  1  sequencer busy level; locks out host while high.
REQ-007 wSeqReady_o  out  1  hardware-ready level back to sequencer.
REQ-008 wHostReq_i / wHostBrdIdx_i / wHostCmd_i  in  1/4/CMDW  host request level, board index, command word.
REQ-009 rHostAck_o / rHostDone_o  out  1/1  host grant pulse / host completion pulse.
REQ-010 rDDSTrig_o / rDDSBrdIdx_o / rDDSCmd_o  out  1/4/CMDW  engine strobe, board index, command.
REQ-011 wDDSBusy_i  in  1  engine busy level.
REQ-012 rGnt_o  out  2  owner: 00 none, 01 sequencer, 10 host.
REQ-013 rOvf_o / rErr_o  out  1/1  sticky sequencer overflow / sticky watchdog error; wErrClr_i (in, 1) clears both.

Function
REQ-014 SHALL capture wSeqTrig_i into a 1-entry pending register (board+cmd) at the trig edge.
REQ-015 wSeqReady_o SHALL be 0 while pending full or rGnt_o==01, else 1 (combinational from registers only).
REQ-016 wSeqTrig_i with pending already full SHALL drop the new command and set rOvf_o.
REQ-017 States: S_IDLE, S_WAITB, S_BUSY, S_DONE.
REQ-018 S_IDLE: pending -> load outputs, rDDSTrig_o<=1 one cycle, rGnt_o<=01, clear pending, -> S_WAITB.
REQ-019 S_IDLE: no pending, wHostReq_i=1, wSeqRun_i=0 -> load host cmd, rDDSTrig_o<=1, rHostAck_o<=1 (one cycle each), rGnt_o<=10, -> S_WAITB.
REQ-020 Simultaneous pending and host request SHALL grant sequencer; host waits.
REQ-021 S_WAITB -> S_BUSY when wDDSBusy_i=1; S_BUSY -> S_DONE when wDDSBusy_i=0.
REQ-022 S_DONE: rHostDone_o<=1 one cycle if rGnt_o==10; rGnt_o<=00; -> S_IDLE.
REQ-023 Latency: sequencer trig at cycle n in idle -> rDDSTrig_o high in cycle n+1, one cycle only.
REQ-024 rDDSCmd_o/rDDSBrdIdx_o SHALL hold value from trig until next grant.
REQ-025 Sequencer trig arriving during a host transaction SHALL be held pending and issued from the following S_IDLE.
REQ-026 Host request dropped before ack SHALL be ignored; no ack, no done.
REQ-027 wErrClr_i concurrent with a new error event: set wins.

Reset
REQ-028 wResetN_i=0 at edge SHALL force S_IDLE, pending empty, all r* outputs 0, watchdog counter 0, mid-transaction included; no done pulse.
REQ-029 wSeqReady_o SHALL read 1 in the first cycle after reset release.

Configuration
REQ-030 Macro DDS_ARB_WDOG_EN defined: 16-bit counter cleared on each state entry, increments in S_WAITB/S_BUSY; reaching TIMEOUT sets rErr_o and forces S_DONE (done pulse still issued to host owner).
REQ-031 Macro undefined: no counter, rErr_o constant 0, S_WAITB/S_BUSY wait indefinitely.

Verification
REQ-032 Idle, seq trig cmd 0x2_0000_1234 brd 1; busy high 3 cycles after -> trig in n+1, rGnt_o=01, wSeqReady_o low until S_IDLE re-entered.
REQ-033 Seq trig and host req same cycle -> seq issued first, host ack one cycle after seq S_DONE completes, host done after its busy falls.
REQ-034 Two seq trigs while engine busy -> first held, second dropped, rOvf_o=1; wErrClr_i pulse -> rOvf_o=0.
REQ-035 wSeqRun_i=1, host req held 100 cycles -> no ack; wSeqRun_i=0 -> ack within 2 cycles.
REQ-036 DDS_ARB_WDOG_EN, TIMEOUT=16, busy never asserts -> rErr_o=1 after 16 cycles in S_WAITB, return to S_IDLE.
REQ-037 Reset asserted in S_BUSY -> next cycle S_IDLE, outputs 0, no rHostDone_o.

Source files
------------

// File: rtl/dds_cmd_arb_if.sv
// Command/handshake bundle between the DDS command arbiter, the sequencer,
// the host and the DDS engine. The arbiter takes the slave view.
interface dds_cmd_arb_if #(
  parameter int unsigned CMDW = 37
);
  logic            wSeqTrig_i;
  logic [3:0]      wSeqBrdIdx_i;
  logic [CMDW-1:0] wSeqCmd_i;
  logic            wSeqRun_i;
  logic            wSeqReady_o;
  logic            wHostReq_i;
  logic [3:0]      wHostBrdIdx_i;
  logic [CMDW-1:0] wHostCmd_i;
  logic            rHostAck_o;
  logic            rHostDone_o;
  logic            rDDSTrig_o;
  logic [3:0]      rDDSBrdIdx_o;
  logic [CMDW-1:0] rDDSCmd_o;
  logic            wDDSBusy_i;
  logic [1:0]      rGnt_o;
  logic            rOvf_o;
  logic            rErr_o;
  logic            wErrClr_i;

  modport slave (
    input  wSeqTrig_i, wSeqBrdIdx_i, wSeqCmd_i, wSeqRun_i,
    input  wHostReq_i, wHostBrdIdx_i, wHostCmd_i,
    input  wDDSBusy_i, wErrClr_i,
    output wSeqReady_o, rHostAck_o, rHostDone_o,
    output rDDSTrig_o, rDDSBrdIdx_o, rDDSCmd_o,
    output rGnt_o, rOvf_o, rErr_o
  );

  modport master (
    output wSeqTrig_i, wSeqBrdIdx_i, wSeqCmd_i, wSeqRun_i,
    output wHostReq_i, wHostBrdIdx_i, wHostCmd_i,
    output wDDSBusy_i, wErrClr_i,
    input  wSeqReady_o, rHostAck_o, rHostDone_o,
    input  rDDSTrig_o, rDDSBrdIdx_o, rDDSCmd_o,
    input  rGnt_o, rOvf_o, rErr_o
  );
endinterface

// File: rtl/dds_cmd_arb.sv
// DDS command arbiter: sequencer (priority, 1-deep pending slot) vs host onto one engine.
// Optional busy-wait watchdog enabled by defining DDS_ARB_WDOG_EN.
module dds_cmd_arb #(
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned CMDW    = 37
) (
  input  logic         wClk_i,
  input  logic         wResetN_i,
  dds_cmd_arb_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_WAITB, S_BUSY, S_DONE} state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_SEQ  = 2'b01;
  localparam logic [1:0] GNT_HOST = 2'b10;

  if (TIMEOUT < 1 || TIMEOUT > 65536) begin : g_timeout_range
    $error("dds_cmd_arb: TIMEOUT must lie in 1..65536");
  end

  state_t          state_reg, state_next;
  logic            pend_valid_reg, pend_valid_next;
  logic [3:0]      pend_brd_reg, pend_brd_next;
  logic [CMDW-1:0] pend_cmd_reg, pend_cmd_next;
  logic            trig_reg, trig_next;
  logic            ack_reg, ack_next;
  logic            done_reg, done_next;
  logic [1:0]      gnt_reg, gnt_next;
  logic [3:0]      brd_reg, brd_next;
  logic [CMDW-1:0] cmd_reg, cmd_next;
  logic            ovf_reg, ovf_next;
  logic            err_reg, err_next;
  logic            ovf_set;
  logic            seq_avail, host_go, seq_grant, host_grant, timeout;

  // A strobe arriving in idle is issued directly so the engine sees it one cycle later.
  assign seq_avail  = pend_valid_reg | bus.wSeqTrig_i;
  assign host_go    = bus.wHostReq_i & ~bus.wSeqRun_i;
  assign seq_grant  = (state_reg == S_IDLE) & seq_avail;
  assign host_grant = (state_reg == S_IDLE) & ~seq_avail & host_go;

`ifdef DDS_ARB_WDOG_EN
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wdog_reg, wdog_next;
  logic        waiting;

  assign waiting   = (state_reg == S_WAITB) | (state_reg == S_BUSY);
  assign timeout   = waiting & (wdog_reg == WDOG_LAST);
  assign wdog_next = (state_next != state_reg) ? 16'd0 :
                     waiting ? wdog_reg + 16'd1 : wdog_reg;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge wClk_i) begin
    if (!wResetN_i) begin
      state_reg      <= S_IDLE;
      pend_valid_reg <= 1'b0;
      pend_brd_reg   <= '0;
      pend_cmd_reg   <= '0;
      trig_reg       <= 1'b0;
      ack_reg        <= 1'b0;
      done_reg       <= 1'b0;
      gnt_reg        <= GNT_NONE;
      brd_reg        <= '0;
      cmd_reg        <= '0;
      ovf_reg        <= 1'b0;
      err_reg        <= 1'b0;
`ifdef DDS_ARB_WDOG_EN
      wdog_reg       <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      pend_valid_reg <= pend_valid_next;
      pend_brd_reg   <= pend_brd_next;
      pend_cmd_reg   <= pend_cmd_next;
      trig_reg       <= trig_next;
      ack_reg        <= ack_next;
      done_reg       <= done_next;
      gnt_reg        <= gnt_next;
      brd_reg        <= brd_next;
      cmd_reg        <= cmd_next;
      ovf_reg        <= ovf_next;
      err_reg        <= err_next;
`ifdef DDS_ARB_WDOG_EN
      wdog_reg       <= wdog_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (seq_avail || host_go) state_next = S_WAITB;
      S_WAITB: begin
        if (timeout)             state_next = S_DONE;
        else if (bus.wDDSBusy_i) state_next = S_BUSY;
      end
      S_BUSY:  if (timeout || !bus.wDDSBusy_i) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    pend_valid_next = pend_valid_reg;
    pend_brd_next   = pend_brd_reg;
    pend_cmd_next   = pend_cmd_reg;
    trig_next       = 1'b0;
    ack_next        = 1'b0;
    done_next       = 1'b0;
    gnt_next        = gnt_reg;
    brd_next        = brd_reg;
    cmd_next        = cmd_reg;
    ovf_set         = 1'b0;

    if (seq_grant) begin
      trig_next = 1'b1;
      gnt_next  = GNT_SEQ;
      if (pend_valid_reg) begin
        brd_next        = pend_brd_reg;
        cmd_next        = pend_cmd_reg;
        pend_valid_next = 1'b0;
      end else begin
        brd_next = bus.wSeqBrdIdx_i;
        cmd_next = bus.wSeqCmd_i;
      end
    end else if (host_grant) begin
      trig_next = 1'b1;
      ack_next  = 1'b1;
      gnt_next  = GNT_HOST;
      brd_next  = bus.wHostBrdIdx_i;
      cmd_next  = bus.wHostCmd_i;
    end

    if (state_reg == S_DONE) begin
      done_next = (gnt_reg == GNT_HOST);
      gnt_next  = GNT_NONE;
    end

    // Strobes not taken by the idle bypass fill the slot, or are lost if it is occupied.
    if (bus.wSeqTrig_i && !(seq_grant && !pend_valid_reg)) begin
      if (pend_valid_reg) begin
        ovf_set = 1'b1;
      end else begin
        pend_valid_next = 1'b1;
        pend_brd_next   = bus.wSeqBrdIdx_i;
        pend_cmd_next   = bus.wSeqCmd_i;
      end
    end

    ovf_next = ovf_set | (ovf_reg & ~bus.wErrClr_i);
    err_next = timeout | (err_reg & ~bus.wErrClr_i);
  end

  assign bus.wSeqReady_o  = ~(pend_valid_reg | (gnt_reg == GNT_SEQ));
  assign bus.rHostAck_o   = ack_reg;
  assign bus.rHostDone_o  = done_reg;
  assign bus.rDDSTrig_o   = trig_reg;
  assign bus.rDDSBrdIdx_o = brd_reg;
  assign bus.rDDSCmd_o    = cmd_reg;
  assign bus.rGnt_o       = gnt_reg;
  assign bus.rOvf_o       = ovf_reg;
  assign bus.rErr_o       = err_reg;
endmodule
